bram_read_ctrl: RTL

BRAM_READ_CTRL -- requirements
Module: bram_read_ctrl

---
 rtl/bram_accessor_pkg.sv | 15 +
 rtl/bram_rd_fifo.sv | 57 +++++
 rtl/bram_read_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bram_accessor_pkg.sv
// Shared definitions for the BRAM burst reader: FSM encoding and read-buffer sizing.
package bram_accessor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/bram_rd_fifo.sv
// Small read-data buffer between the BRAM and the output stream; flush wins over push/pop.
module bram_rd_fifo
    import bram_accessor_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [FIFO_CNT_W-1:0] count,
    output logic [DATA_WIDTH-1:0] data
);

    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [FIFO_PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign data  = mem_q[rd_q];

endmodule

// File: rtl/bram_read_ctrl.sv
// Burst reader: issues len BRAM reads from base (wrapping) and streams the words out
// through a 2-deep buffer with valid/ready flow control.
module bram_read_ctrl
    import bram_accessor_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  abort_i,
    output logic                  bram_en_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    input  logic [DATA_WIDTH-1:0] bram_rdata_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CW = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
    logic [CW-1:0]         len_q, len_d, issued_q, issued_d, accepted_q, accepted_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [FIFO_CNT_W:0]   occ;
    logic                  pop, flush, room;

    bram_rd_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_vld_q),
        .push_data (bram_rdata_i),
        .pop       (pop),
        .flush     (flush),
        .count     (fifo_count),
        .data      (m_data_o)
    );

    assign m_valid_o = (fifo_count != '0);
    assign pop       = m_valid_o & m_ready_i;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);

    // Buffered words plus the one read whose data lands this cycle, less this cycle's pop.
    assign occ  = {1'b0, fifo_count} + (FIFO_CNT_W+1)'(rd_vld_q);
    assign room = occ < ((FIFO_CNT_W+1)'(FIFO_DEPTH) + (FIFO_CNT_W+1)'(pop));

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        accepted_d  = accepted_q;
        addr_d      = addr_q;
        rd_vld_d    = 1'b0;
        flush       = 1'b0;
        bram_en_o   = 1'b0;
        bram_addr_o = addr_q;
        if (pop) accepted_d = accepted_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    base_d     = base_addr_i;
                    len_d      = len_i;
                    issued_d   = '0;
                    accepted_d = '0;
                    state_d    = (len_i == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if ((issued_q != len_q) && room) begin
                    bram_en_o   = 1'b1;
                    bram_addr_o = base_q + issued_q[ADDR_WIDTH-1:0];
                    addr_d      = bram_addr_o;
                    issued_d    = issued_q + CW'(1);
                    rd_vld_d    = 1'b1;
                    if (issued_d == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (accepted_d == len_q)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort pre-empts everything, including a read that would issue this cycle.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            flush       = 1'b1;
            rd_vld_d    = 1'b0;
            bram_en_o   = 1'b0;
            bram_addr_o = addr_q;
            addr_d      = addr_q;
            issued_d    = issued_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            addr_q     <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            addr_q     <= addr_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

endmodule
